// File: rtl/ysyx_22040632_ctrl_fsm.sv
// +----------------------------------------------------------------------------+
// | ysyx_22040632_ctrl_fsm: multi-cycle NPC sequencer (fetch/decode/mem/wb).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ysyx_22040632_ctrl_fsm #(
  parameter logic [63:0] PC_RESET      = 64'h8000_0000,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rrst_n,
  input  logic        start,
  output logic        ifu_req,
  output logic [63:0] ifu_addr,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_inst,
  output logic [31:0] inst,
  input  logic        dec_mem,
  input  logic        dec_jump,
  input  logic [63:0] jump_target,
  input  logic        dec_ebreak,
  input  logic        dec_illegal,
  output logic        lsu_req,
  input  logic        lsu_done,
  output logic        rf_we,
  output logic [63:0] pc,
  output logic        retire,
  output logic [63:0] instret,
  output logic        halted,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam logic [15:0] C_TIMEOUT      = 16'(FETCH_TIMEOUT);
  localparam logic [1:0]  C_ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0]  C_ERR_ILLEGAL  = 2'd2;
  localparam logic [1:0]  C_ERR_MISALIGN = 2'd3;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_err_code;
  logic [1:0]  w_err_code_nxt;
  logic [15:0] r_tmo_cnt;
  logic [31:0] r_inst;
  logic [63:0] r_pc;
  logic [63:0] r_instret;
  logic        r_halt_entry;
  logic        w_retire;

  always_comb begin
    w_state_nxt    = r_state;
    w_err_code_nxt = r_err_code;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (ifu_rsp_valid) begin
          w_state_nxt = S_DECODE;
        end else if (r_tmo_cnt + 16'd1 == C_TIMEOUT) begin
          w_state_nxt    = S_ERROR;
          w_err_code_nxt = C_ERR_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          w_state_nxt    = S_ERROR;
          w_err_code_nxt = C_ERR_ILLEGAL;
        end else if (dec_ebreak) begin
          w_state_nxt = S_HALT;
        end else if (dec_jump && (jump_target[1:0] != 2'b00)) begin
          w_state_nxt    = S_ERROR;
          w_err_code_nxt = C_ERR_MISALIGN;
        end else if (dec_mem) begin
          w_state_nxt = S_MEM;
        end else begin
          w_state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (lsu_done) w_state_nxt = S_WB;
      end
      S_WB:    w_state_nxt = S_FETCH;
      S_HALT:  w_state_nxt = S_HALT;
      S_ERROR: w_state_nxt = S_ERROR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // HALT retires the ebreak only in its first cycle, so that cycle is flagged separately.
  assign w_retire = (r_state == S_WB) || r_halt_entry;

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state      <= S_IDLE;
      r_err_code   <= 2'd0;
      r_tmo_cnt    <= 16'd0;
      r_inst       <= 32'd0;
      r_pc         <= PC_RESET;
      r_instret    <= 64'd0;
      r_halt_entry <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_err_code   <= w_err_code_nxt;
      r_halt_entry <= (r_state == S_DECODE) && (w_state_nxt == S_HALT);
      if (r_state == S_FETCH) begin
        if (ifu_rsp_valid) begin
          r_inst    <= ifu_rsp_inst;
          r_tmo_cnt <= 16'd0;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
      end
      if (r_state == S_WB) begin
        r_pc <= dec_jump ? jump_target : r_pc + 64'd4;
      end
      if (w_retire) begin
        r_instret <= r_instret + 64'd1;
      end
    end
  end

  assign ifu_req  = (r_state == S_FETCH);
  assign ifu_addr = r_pc;
  assign inst     = r_inst;
  assign lsu_req  = (r_state == S_MEM);
  assign rf_we    = (r_state == S_WB);
  assign pc       = r_pc;
  assign retire   = w_retire;
  assign instret  = r_instret;
  assign halted   = (r_state == S_HALT);
  assign err      = (r_state == S_ERROR);
  assign err_code = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040632_ctrl_fsm.sv
// +----------------------------------------------------------------------------+
// | tb_ysyx_22040632_ctrl_fsm: scoreboard bench for the NPC sequencer.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ysyx_22040632_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rrst_n = 1'b0;
  logic        start = 1'b0;
  logic        ifu_req;
  logic [63:0] ifu_addr;
  logic        ifu_rsp_valid = 1'b0;
  logic [31:0] ifu_rsp_inst = 32'd0;
  logic [31:0] inst;
  logic        dec_mem = 1'b0;
  logic        dec_jump = 1'b0;
  logic [63:0] jump_target = 64'd0;
  logic        dec_ebreak = 1'b0;
  logic        dec_illegal = 1'b0;
  logic        lsu_req;
  logic        lsu_done = 1'b0;
  logic        rf_we;
  logic [63:0] pc;
  logic        retire;
  logic [63:0] instret;
  logic        halted;
  logic        err;
  logic [1:0]  err_code;

  ysyx_22040632_ctrl_fsm dut (
    .clk           (clk),
    .rrst_n        (rrst_n),
    .start         (start),
    .ifu_req       (ifu_req),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_inst  (ifu_rsp_inst),
    .inst          (inst),
    .dec_mem       (dec_mem),
    .dec_jump      (dec_jump),
    .jump_target   (jump_target),
    .dec_ebreak    (dec_ebreak),
    .dec_illegal   (dec_illegal),
    .lsu_req       (lsu_req),
    .lsu_done      (lsu_done),
    .rf_we         (rf_we),
    .pc            (pc),
    .retire        (retire),
    .instret       (instret),
    .halted        (halted),
    .err           (err),
    .err_code      (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_err;
    logic [31:0] inst;
    logic        rf_we;
    logic        halted;
    logic [1:0]  code;
    logic [63:0] pc;
    logic [63:0] instret;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [31:0] C_ADDI   = 32'h0010_0093;
  localparam logic [31:0] C_JAL    = 32'h1000_006f;
  localparam logic [31:0] C_LOAD   = 32'h0000_3083;
  localparam logic [31:0] C_EBREAK = 32'h0010_0073;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_ret(input logic [31:0] i, input logic we, input logic h,
                                  input logic [63:0] p, input logic [63:0] n);
    exp_t e;
    e.is_err = 1'b0; e.inst = i; e.rf_we = we; e.halted = h;
    e.code = 2'd0; e.pc = p; e.instret = n;
    return e;
  endfunction

  function automatic exp_t mk_err(input logic [1:0] c, input logic [63:0] p, input logic [63:0] n);
    exp_t e;
    e.is_err = 1'b1; e.inst = 32'd0; e.rf_we = 1'b0; e.halted = 1'b0;
    e.code = c; e.pc = p; e.instret = n;
    return e;
  endfunction

  // Monitor: every retire pulse and every err rising edge consumes one expected record.
  initial begin
    logic prev_err;
    exp_t e;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rrst_n) begin
        prev_err = 1'b0;
        continue;
      end
      if (rf_we) chk("rf_we_implies_retire", 64'(retire), 64'd1);
      if (retire) begin
        if (q.size() == 0) begin
          chk("unexpected_retire", 64'(q.size()), 64'd1);
        end else begin
          e = q.pop_front();
          chk("retire_kind", 64'(e.is_err), 64'd0);
          chk("retire_rf_we", 64'(rf_we), 64'(e.rf_we));
          chk("retire_inst", 64'(inst), 64'(e.inst));
          chk("retire_halted", 64'(halted), 64'(e.halted));
          @(negedge clk);
          chk("retire_pc_after", pc, e.pc);
          chk("retire_instret_after", instret, e.instret);
        end
      end
      if (err && !prev_err) begin
        if (q.size() == 0) begin
          chk("unexpected_err", 64'(q.size()), 64'd1);
        end else begin
          e = q.pop_front();
          chk("err_kind", 64'(e.is_err), 64'd1);
          chk("err_code", 64'(err_code), 64'(e.code));
          chk("err_pc", pc, e.pc);
          chk("err_instret", instret, e.instret);
          chk("err_ifu_req", 64'(ifu_req), 64'd0);
        end
      end
      prev_err = err;
    end
  end

  task automatic do_reset();
    rrst_n = 1'b0;
    ifu_rsp_valid = 1'b0; lsu_done = 1'b0; start = 1'b0;
    dec_mem = 1'b0; dec_jump = 1'b0; dec_ebreak = 1'b0; dec_illegal = 1'b0;
    @(negedge clk);
    rrst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ifu_req();
    int n = 0;
    while (!ifu_req && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!ifu_req) chk("ifu_req_wait", 64'(ifu_req), 64'd1);
  endtask

  // Answers the pending fetch after dly FETCH cycles; returns at the DECODE negedge.
  task automatic fetch(input logic [31:0] code, input int dly, input logic m, input logic j,
                       input logic [63:0] tgt, input logic e, input logic il, input logic spur);
    wait_ifu_req();
    if (spur) begin
      lsu_done = 1'b1;
      @(negedge clk);
      lsu_done = 1'b0;
    end
    repeat (dly) @(negedge clk);
    ifu_rsp_valid = 1'b1; ifu_rsp_inst = code;
    dec_mem = m; dec_jump = j; jump_target = tgt; dec_ebreak = e; dec_illegal = il;
    @(negedge clk);
    ifu_rsp_valid = 1'b0;
  endtask

  task automatic lsu(input int n);
    int w = 0;
    int cnt = 0;
    while (!lsu_req && w < 2000) begin
      @(negedge clk);
      w++;
    end
    while (lsu_req && cnt < 100) begin
      cnt++;
      lsu_done = (cnt == n);
      @(negedge clk);
    end
    lsu_done = 1'b0;
    chk("lsu_req_cycles", 64'(cnt), 64'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    int bad;

    // Reset state
    @(negedge clk);
    chk("rst_pc", pc, 64'h8000_0000);
    chk("rst_ifu_addr", ifu_addr, 64'h8000_0000);
    chk("rst_instret", instret, 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_flags", {58'd0, ifu_req, lsu_req, rf_we, retire, halted, err}, 64'd0);
    chk("rst_err_code", 64'(err_code), 64'd0);
    rrst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_req", 64'(ifu_req), 64'd0);

    // Test 1: addi answered 2 cycles into FETCH
    pulse_start();
    q.push_back(mk_ret(C_ADDI, 1'b1, 1'b0, 64'h8000_0004, 64'd1));
    fetch(C_ADDI, 2, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("t1_ifu_req_again", 64'(ifu_req), 64'd1);
    chk("t1_ifu_addr", ifu_addr, 64'h8000_0004);

    // Test 2: aligned jal then misaligned target
    q.push_back(mk_ret(C_JAL, 1'b1, 1'b0, 64'h8000_0100, 64'd2));
    fetch(C_JAL, 0, 1'b0, 1'b1, 64'h8000_0100, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("t2_ifu_addr_jump", ifu_addr, 64'h8000_0100);
    q.push_back(mk_err(2'd3, 64'h8000_0100, 64'd2));
    fetch(C_JAL, 0, 1'b0, 1'b1, 64'h8000_0102, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("t2_err_sticky", 64'(err), 64'd1);

    // Test 3: loads with spurious lsu_done during FETCH
    do_reset();
    pulse_start();
    q.push_back(mk_ret(C_LOAD, 1'b1, 1'b0, 64'h8000_0004, 64'd1));
    fetch(C_LOAD, 1, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    lsu(3);
    q.push_back(mk_ret(C_LOAD, 1'b1, 1'b0, 64'h8000_0008, 64'd2));
    fetch(C_LOAD, 0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    lsu(1);

    // Test 4: ebreak halts; start and IFU responses ignored afterwards
    q.push_back(mk_ret(C_EBREAK, 1'b0, 1'b1, 64'h8000_0008, 64'd3));
    fetch(C_EBREAK, 0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      start = 1'b1;
      ifu_rsp_valid = i[0];
      @(negedge clk);
      if (ifu_req || !halted) bad++;
    end
    start = 1'b0;
    ifu_rsp_valid = 1'b0;
    chk("t4_halt_violations", 64'(bad), 64'd0);
    chk("t4_pc_frozen", pc, 64'h8000_0008);
    chk("t4_instret", instret, 64'd3);

    // Test 5: fetch timeout, then illegal beats ebreak
    do_reset();
    pulse_start();
    q.push_back(mk_err(2'd1, 64'h8000_0000, 64'd0));
    wait_ifu_req();
    cnt = 0;
    while (ifu_req && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    chk("t5_ifu_req_cycles", 64'(cnt), 64'd255);
    chk("t5_err", 64'(err), 64'd1);
    do_reset();
    pulse_start();
    q.push_back(mk_err(2'd2, 64'h8000_0000, 64'd0));
    fetch(C_EBREAK, 0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("t5_not_halted", 64'(halted), 64'd0);

    // Test 6: asynchronous reset in the middle of MEM
    do_reset();
    pulse_start();
    q.push_back(mk_ret(C_ADDI, 1'b1, 1'b0, 64'h8000_0004, 64'd1));
    fetch(C_ADDI, 0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    fetch(C_LOAD, 0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t6_in_mem", 64'(lsu_req), 64'd1);
    rrst_n = 1'b0;
    #1;
    chk("t6_lsu_req_drop", 64'(lsu_req), 64'd0);
    chk("t6_pc_reset", pc, 64'h8000_0000);
    chk("t6_instret_reset", instret, 64'd0);
    chk("t6_inst_reset", 64'(inst), 64'd0);
    @(negedge clk);
    rrst_n = 1'b1;
    dec_mem = 1'b0;
    @(negedge clk);
    pulse_start();
    q.push_back(mk_ret(C_ADDI, 1'b1, 1'b0, 64'h8000_0004, 64'd1));
    fetch(C_ADDI, 1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);

    chk("scoreboard_leftover", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ysyx_22040632_ctrl_fsm.md
Name: ysyx_22040632_ctrl_fsm

Overview:
Multi-cycle core sequencer for the NPC.
- Drives the instruction-fetch handshake, holds the fetched instruction for the decoder and sequences the optional memory stage.
- Issues the single-cycle register-file write enable (the decoder's rdy input) and owns the PC and retired-instruction counter.
- Sits between IFU, IDU/EXU, LSU and the simulation harness; halts on ebreak and faults on fetch timeout, illegal instruction or misaligned jump target.

Parameters:
PC_RESET, 64'h8000_0000, PC value after reset
FETCH_TIMEOUT, 255, max cycles in FETCH without response before fault (legal range 1..65535)

Ports:
clk  in  1  clock
rrst_n  in  1  reset, asynchronous, active-low
start  in  1  leave IDLE and begin execution
ifu_req  out  1  fetch request, held high in FETCH
ifu_addr  out  64  fetch address, equals pc
ifu_rsp_valid  in  1  fetch response valid
ifu_rsp_inst  in  32  fetched instruction
inst  out  32  latched instruction to decoder
dec_mem  in  1  decoded instruction needs LSU stage
dec_jump  in  1  decoded instruction redirects PC
jump_target  in  64  redirect target
dec_ebreak  in  1  decoded instruction is ebreak
dec_illegal  in  1  decoded instruction not implemented
lsu_req  out  1  memory request, held high in MEM
lsu_done  in  1  memory access complete
rf_we  out  1  register-file write enable, one-cycle pulse
pc  out  64  architectural PC
retire  out  1  one-cycle pulse per retired instruction
instret  out  64  retired-instruction count
halted  out  1  sticky, ebreak reached
err  out  1  sticky fault flag
err_code  out  2  0 none, 1 fetch timeout, 2 illegal, 3 misaligned target

Behaviour:
- Reset values: state IDLE, pc=PC_RESET, inst=0, instret=0, timeout counter=0; all other outputs 0. Reset is asynchronous: outputs clear immediately in any state, including mid-MEM, where lsu_req drops without waiting for lsu_done.
- States: IDLE, FETCH, DECODE, MEM, WB, HALT, ERROR. All outputs except ifu_addr, inst, pc and instret are registered or state-decoded only.
- IDLE:
  - start=1 moves to FETCH next cycle.
  - start is ignored in every other state.
- FETCH:
  - ifu_req=1.
  - On ifu_rsp_valid: latch ifu_rsp_inst into inst, clear the counter, go to DECODE. A response in the first FETCH cycle is legal.
  - Otherwise the counter increments. When the counter reaches FETCH_TIMEOUT: go to ERROR with err_code=1.
  - ifu_rsp_valid is ignored outside FETCH.
- DECODE (1 cycle). Decoder inputs are combinational from inst and stable DECODE..WB. Priority, highest first:
  1. dec_illegal: ERROR, code 2.
  2. dec_ebreak: HALT.
  3. dec_jump with jump_target[1:0]!=0: ERROR, code 3.
  4. dec_mem: MEM.
  5. Otherwise: WB.
- MEM:
  - lsu_req=1 until lsu_done is sampled high, then go to WB.
  - lsu_done outside MEM is ignored. There is no timeout in MEM.
- WB (1 cycle):
  - rf_we=1, retire=1, instret+1.
  - pc <= dec_jump ? jump_target : pc+4, using modulo-2^64 addition; wrap is allowed.
  - Next state is FETCH.
- HALT:
  - Entry cycle: retire=1 and instret+1; rf_we stays 0.
  - halted=1, sticky until reset. pc is not advanced.
- ERROR:
  - err=1 and err_code hold until reset. No retire; pc frozen.
- Latency and throughput:
  - Non-memory instruction: minimum 3 cycles (FETCH, DECODE, WB).
  - Memory instruction: minimum 4 cycles.
- instret wraps 2^64-1 -> 0.

Test Plan:
1. Reset, start=1, IFU answers addi 2 cycles after ifu_req, dec_mem=0 -> exactly one rf_we/retire pulse 2 cycles after the response, pc=0x8000_0004, instret=1, ifu_req high again next cycle.
2. jal with dec_jump=1, jump_target=0x8000_0100 -> rf_we pulse, pc=0x8000_0100, ifu_addr=0x8000_0100 in the following FETCH. Then jump_target=0x8000_0102 -> err=1, err_code=3, no rf_we.
3. Load with dec_mem=1, lsu_done 3 cycles after MEM entry -> lsu_req high exactly 3 cycles, then rf_we pulse. A spurious lsu_done in FETCH has no effect.
4. ebreak -> halted=1, instret+1, rf_we stays 0; later start pulses and IFU responses are ignored and ifu_req stays 0.
5. IFU never responds -> ifu_req high for 255 cycles, then err=1, err_code=1. Also dec_illegal=1 together with dec_ebreak=1 -> err_code=2.
6. rrst_n asserted mid-MEM -> lsu_req=0 in the same cycle, pc=0x8000_0000, instret=0. After release and start, execution resumes normally.
